blend_pipe: RTL



---
 rtl/blend_pipe_if.sv | 30 +++
 rtl/blend_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/blend_pipe_if.sv
// Pixel stream bundle for blend_pipe: input pixel/coefficients with valid/ready,
// result pixel with valid/ready and saturation flag.
interface blend_pipe_if #(
    parameter int unsigned CW   = 5,
    parameter int unsigned NCH  = 3,
    parameter int unsigned FRAC = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [NCH*CW-1:0]   in_first;
    logic [NCH*CW-1:0]   in_second;
    logic [1:0]          in_mode;
    logic [FRAC:0]       in_eva;
    logic [FRAC:0]       in_evb;
    logic [FRAC:0]       in_evy;
    logic                out_valid;
    logic                out_ready;
    logic [NCH*CW-1:0]   out_color;
    logic                out_sat;

    modport master (
        output in_valid, in_first, in_second, in_mode, in_eva, in_evb, in_evy, out_ready,
        input  in_ready, out_valid, out_color, out_sat
    );

    modport slave (
        input  in_valid, in_first, in_second, in_mode, in_eva, in_evb, in_evy, out_ready,
        output in_ready, out_valid, out_color, out_sat
    );
endinterface

// File: rtl/blend_pipe.sv
// Two-stage colour effects pipeline: S1 forms per-channel coefficient products,
// S2 shifts, saturates and registers the pixel. One global stall enable.
module blend_pipe #(
    parameter int unsigned CW   = 5,
    parameter int unsigned NCH  = 3,
    parameter int unsigned FRAC = 4
) (
    input  logic        clock,
    input  logic        reset,
    blend_pipe_if.slave bus
);
    localparam int unsigned MAX = (2 ** CW) - 1;
    localparam int unsigned U   = 2 ** FRAC;
    localparam int unsigned CFW = FRAC + 1;
    localparam int unsigned PW  = CW + CFW;
    localparam int unsigned SW  = CW + FRAC + 2;
    localparam int unsigned DW  = NCH * CW;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_BLEND  = 2'b01,
        MODE_BRIGHT = 2'b10,
        MODE_DARK   = 2'b11
    } mode_e;

    // Any coefficient with the top bit set is at or above unity.
    function automatic logic [CFW-1:0] clamp_coef(input logic [CFW-1:0] c);
        return c[FRAC] ? CFW'(U) : c;
    endfunction

    function automatic logic [2*PW-1:0] products(
        input mode_e          m,
        input logic [CW-1:0]  f,
        input logic [CW-1:0]  s,
        input logic [CFW-1:0] eva,
        input logic [CFW-1:0] evb,
        input logic [CFW-1:0] evy
    );
        logic [PW-1:0] p1;
        logic [PW-1:0] p2;
        p1 = '0;
        p2 = '0;
        case (m)
            MODE_BLEND: begin
                p1 = PW'(f) * PW'(clamp_coef(eva));
                p2 = PW'(s) * PW'(clamp_coef(evb));
            end
            MODE_BRIGHT: p1 = PW'(CW'(MAX) - f) * PW'(clamp_coef(evy));
            MODE_DARK:   p1 = PW'(f) * PW'(clamp_coef(evy));
            default:     p1 = '0;
        endcase
        return {p2, p1};
    endfunction

    // Returns {sat, channel}; sat only ever raised by a clamped blend.
    function automatic logic [CW:0] chan_result(
        input mode_e         m,
        input logic [CW-1:0] f,
        input logic [PW-1:0] p1,
        input logic [PW-1:0] p2
    );
        logic [SW-1:0] s;
        logic [CW-1:0] r;
        logic          sat;
        s   = '0;
        r   = f;
        sat = 1'b0;
        case (m)
            MODE_BLEND: begin
                s = (SW'(p1) + SW'(p2)) >> FRAC;
                if (s > SW'(MAX)) begin
                    r   = CW'(MAX);
                    sat = 1'b1;
                end else begin
                    r = CW'(s);
                end
            end
            MODE_BRIGHT: begin
                s = SW'(f) + (SW'(p1) >> FRAC);
                r = (s > SW'(MAX)) ? CW'(MAX) : CW'(s);
            end
            MODE_DARK: begin
                s = SW'(p1) >> FRAC;
                r = (s > SW'(f)) ? '0 : CW'(SW'(f) - s);
            end
            default: r = f;
        endcase
        return {sat, r};
    endfunction

    logic          adv;
    logic          v1_q,     v1_d;
    mode_e         mode1_q,  mode1_d;
    logic [DW-1:0] first1_q, first1_d;
    logic [PW-1:0] p1_q [NCH];
    logic [PW-1:0] p1_d [NCH];
    logic [PW-1:0] p2_q [NCH];
    logic [PW-1:0] p2_d [NCH];
    logic          v2_q,     v2_d;
    logic [DW-1:0] color_q,  color_d;
    logic          sat_q,    sat_d;
    logic [CW:0]   res_c [NCH];

    assign adv           = !v2_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v2_q;
    assign bus.out_color = color_q;
    assign bus.out_sat   = sat_q;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            res_c[k] = chan_result(mode1_q, first1_q[k*CW +: CW], p1_q[k], p2_q[k]);
        end
    end

    // Next state: both stages advance together when the output is free.
    always_comb begin
        v1_d     = v1_q;
        mode1_d  = mode1_q;
        first1_d = first1_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        v2_d     = v2_q;
        color_d  = color_q;
        sat_d    = sat_q;
        if (adv) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                mode1_d  = mode_e'(bus.in_mode);
                first1_d = bus.in_first;
                for (int k = 0; k < NCH; k++) begin
                    {p2_d[k], p1_d[k]} = products(mode_e'(bus.in_mode),
                                                  bus.in_first[k*CW +: CW],
                                                  bus.in_second[k*CW +: CW],
                                                  bus.in_eva, bus.in_evb, bus.in_evy);
                end
            end
            v2_d = v1_q;
            if (v1_q) begin
                sat_d = 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    color_d[k*CW +: CW] = res_c[k][CW-1:0];
                    sat_d               = sat_d | res_c[k][CW];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            color_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            color_q <= color_d;
            sat_q   <= sat_d;
        end
    end

    // S1 payload needs no reset; its valid bit qualifies it.
    always_ff @(posedge clock) begin
        mode1_q  <= mode1_d;
        first1_q <= first1_d;
        p1_q     <= p1_d;
        p2_q     <= p2_d;
    end
endmodule
